ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Two-master AHB-lite arbiter and address/write-data multiplexer placed in front of the system AHB bus.
- Lets the CPU (M0) and a DMA engine (M1) share the slave fabric: QSPI XIP, SRAM, GPIO, debug register and the APB subsystem.
- Uses HBUSREQ/HGRANT request-grant per master with a round-robin policy, a per-tenure beat limit for fairness, and parking on a default master.
- HRDATA and HREADY from the bus are broadcast to both masters outside this block.

Parameters:
- DEFAULT_MASTER, 0, master that holds grant and owns the bus when nobody requests (0 or 1)
- MAX_BEATS, 8, accepted NONSEQ/SEQ address phases an owner may issue while the other master waits; range 1..255

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  asynchronous reset, active-high
- HBUSREQ_M0  in  1  M0 bus request
- HADDR_M0  in  32  M0 address
- HTRANS_M0  in  2  M0 transfer type
- HWRITE_M0  in  1  M0 write
- HSIZE_M0  in  3  M0 size
- HWDATA_M0  in  32  M0 write data
- HGRANT_M0  out  1  M0 grant
- HBUSREQ_M1, HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HWDATA_M1  in  1/32/2/1/3/32  M1 equivalents
- HGRANT_M1  out  1  M1 grant
- HREADY  in  1  bus HREADY, as seen by all masters
- HADDR  out  32  muxed address to bus
- HTRANS  out  2  muxed transfer type
- HWRITE  out  1  muxed write
- HSIZE  out  3  muxed size
- HWDATA  out  32  muxed write data
- HMASTER  out  1  current address-phase owner

Behaviour:
Registers:
- grant (1b): drives HGRANT_M0 = (grant==0) and HGRANT_M1 = (grant==1).
- addr_owner (1b): drives HMASTER.
- data_owner (1b).
- beats: $clog2(MAX_BEATS+1) bits.

Reset (HRESET=1, asynchronous):
- grant = addr_owner = data_owner = DEFAULT_MASTER; beats = 0.
- HGRANT of DEFAULT_MASTER = 1, the other = 0.
- Bus outputs follow DEFAULT_MASTER's inputs combinationally.

Address mux (combinational):
- HADDR/HTRANS/HWRITE/HSIZE = the addr_owner master's signals.

Data mux (combinational):
- HWDATA = the data_owner master's HWDATA.

Ownership pipeline (on each HCLK edge with HREADY=1):
- data_owner <= addr_owner.
- addr_owner <= grant.
- When HREADY=0, both hold. Ownership never changes mid wait-state.

Beat counter (on edge with HREADY=1):
- If grant != addr_owner (handover occurring): beats <= 0.
- Else if HTRANS[1]: beats <= beats+1, saturating at MAX_BEATS.
- Else: beats holds.

Grant arbitration (evaluated every edge, independent of HREADY), rules in priority order:
1. Neither request -> grant <= DEFAULT_MASTER.
2. Exactly one request -> grant <= that master.
3. Both request and grant != addr_owner (handover pending) -> grant holds.
4. Both request and beats < MAX_BEATS -> grant holds.
5. Both request and beats == MAX_BEATS -> grant <= ~grant (round-robin).

Handover and burst rules:
- A master whose grant drops mid-burst has its burst cut. It must drive IDLE or re-request and restart with NONSEQ. The arbiter does not check this.
- A master that loses grant while HREADY=0 still owns the address phase until HREADY=1.

Latency:
- Request to grant: 1 cycle.
- Grant to address ownership: first HREADY=1 edge after grant.
- Address to data ownership: next HREADY=1 edge.

Simultaneous events:
- A request deasserting in the same cycle as beats reaching MAX_BEATS is handled by rules 1/2 taking precedence.
- Reset mid-transfer abandons all state immediately, with no drain.

Test Plan:
- Reset release, no requests, DEFAULT_MASTER=0 -> HGRANT_M0=1, HMASTER=0, HTRANS passes HTRANS_M0=IDLE, beats=0.
- M1 requests alone, HREADY=1 -> HGRANT_M1=1 one cycle later; HMASTER=1 one cycle after that; HWDATA switches to HWDATA_M1 one further cycle later.
- Both request continuously, M0 owner, 8-beat INCR with HREADY=1 (MAX_BEATS=8) -> grant flips to M1 after the 8th accepted beat; M1 keeps it for 8 beats, then grant returns to M0.
- Handover edge with HREADY=0 for 3 cycles -> HMASTER and data_owner hold; switch occurs on the first HREADY=1 edge; no HWDATA glitch to the new owner during the stalled data phase.
- M0 owner at beats=8, M1 request drops in the same cycle -> grant stays M0, beats stays saturated; a later M1 request is granted on the next edge.
- HRESET asserted mid-burst owned by M1 -> HMASTER=0, HGRANT_M0=1 and bus outputs equal M0 inputs within the same cycle, with no clock required.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signal bundle for the two-master AHB-lite arbiter.
// The master modport is the requester/bus-driver view; the slave modport is the arbiter itself.
interface ahb_bus_arbiter_if;
    logic        HBUSREQ_M0;
    logic [31:0] HADDR_M0;
    logic [1:0]  HTRANS_M0;
    logic        HWRITE_M0;
    logic [2:0]  HSIZE_M0;
    logic [31:0] HWDATA_M0;
    logic        HGRANT_M0;
    logic        HBUSREQ_M1;
    logic [31:0] HADDR_M1;
    logic [1:0]  HTRANS_M1;
    logic        HWRITE_M1;
    logic [2:0]  HSIZE_M1;
    logic [31:0] HWDATA_M1;
    logic        HGRANT_M1;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HMASTER;

    modport slave (
        input  HBUSREQ_M0, HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HWDATA_M0,
        input  HBUSREQ_M1, HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HWDATA_M1,
        input  HREADY,
        output HGRANT_M0, HGRANT_M1, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER
    );

    modport master (
        output HBUSREQ_M0, HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HWDATA_M0,
        output HBUSREQ_M1, HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HWDATA_M1,
        output HREADY,
        input  HGRANT_M0, HGRANT_M1, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-lite arbiter: round-robin grant with a per-tenure beat limit,
// parking on DEFAULT_MASTER, and address/data ownership pipelined on HREADY.
module ahb_bus_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_BEATS      = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_bus_arbiter_if.slave  bus
);
    localparam int unsigned   BW        = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BEATS);
    localparam logic          DEF_M     = (DEFAULT_MASTER != 0) ? 1'b1 : 1'b0;

    logic          grant_q,      grant_d;
    logic          addr_owner_q, addr_owner_d;
    logic          data_owner_q, data_owner_d;
    logic [BW-1:0] beats_q,      beats_d;

    // State register with immediate, drain-free reset to the parking master
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q      <= DEF_M;
            addr_owner_q <= DEF_M;
            data_owner_q <= DEF_M;
            beats_q      <= '0;
        end else begin
            grant_q      <= grant_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            beats_q      <= beats_d;
        end
    end

    // Next-state: grant arbitration every edge, ownership and beat count only on HREADY
    always_comb begin
        grant_d      = grant_q;
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        beats_d      = beats_q;

        case ({bus.HBUSREQ_M1, bus.HBUSREQ_M0})
            2'b00:   grant_d = DEF_M;
            2'b01:   grant_d = 1'b0;
            2'b10:   grant_d = 1'b1;
            2'b11: begin
                // Pending handover or unexhausted tenure keeps the grant where it is
                if ((grant_q != addr_owner_q) || (beats_q < BEATS_MAX)) begin
                    grant_d = grant_q;
                end else begin
                    grant_d = ~grant_q;
                end
            end
            default: grant_d = DEF_M;
        endcase

        if (bus.HREADY) begin
            data_owner_d = addr_owner_q;
            addr_owner_d = grant_q;
            if (grant_q != addr_owner_q) begin
                beats_d = '0;
            end else if (bus.HTRANS[1] && (beats_q < BEATS_MAX)) begin
                beats_d = beats_q + BW'(1);
            end else begin
                beats_d = beats_q;
            end
        end else begin
            data_owner_d = data_owner_q;
            addr_owner_d = addr_owner_q;
            beats_d      = beats_q;
        end
    end

    // Outputs: grants and the address/data multiplexers
    always_comb begin
        bus.HGRANT_M0 = ~grant_q;
        bus.HGRANT_M1 = grant_q;
        bus.HMASTER   = addr_owner_q;

        if (addr_owner_q) begin
            bus.HADDR  = bus.HADDR_M1;
            bus.HTRANS = bus.HTRANS_M1;
            bus.HWRITE = bus.HWRITE_M1;
            bus.HSIZE  = bus.HSIZE_M1;
        end else begin
            bus.HADDR  = bus.HADDR_M0;
            bus.HTRANS = bus.HTRANS_M0;
            bus.HWRITE = bus.HWRITE_M0;
            bus.HSIZE  = bus.HSIZE_M0;
        end

        if (data_owner_q) begin
            bus.HWDATA = bus.HWDATA_M1;
        end else begin
            bus.HWDATA = bus.HWDATA_M0;
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: hand-computed vector table, reference-model scoreboard,
// and directed sequences for saturation, round-robin period and asynchronous reset.
module tb_ahb_bus_arbiter;
    localparam int MAXB = 8;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic HCLK = 1'b0;
    logic HRESET;

    ahb_bus_arbiter_if bus();

    ahb_bus_arbiter #(.DEFAULT_MASTER(0), .MAX_BEATS(MAXB)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        g0, g1, hm;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr, hwdata;
    } exp_t;

    typedef struct {
        logic       r0, r1;
        logic [1:0] t0, t1;
        logic       rdy;
        logic       eg, ehm, edm;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tab[11];
    int          checks = 0;
    int          errors = 0;
    logic        m_g, m_a, m_d;
    int          m_b;
    logic [23:0] cnt = 24'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [1:0] t0,
                         input logic [1:0] t1, input logic rdy);
        cnt++;
        bus.HBUSREQ_M0 = r0;
        bus.HBUSREQ_M1 = r1;
        bus.HTRANS_M0  = t0;
        bus.HTRANS_M1  = t1;
        bus.HADDR_M0   = {8'hA0, cnt};
        bus.HADDR_M1   = {8'hA1, cnt};
        bus.HWDATA_M0  = {8'hD0, cnt};
        bus.HWDATA_M1  = {8'hD1, cnt};
        bus.HWRITE_M0  = 1'b0;
        bus.HWRITE_M1  = 1'b1;
        bus.HSIZE_M0   = 3'd2;
        bus.HSIZE_M1   = 3'd1;
        bus.HREADY     = rdy;
    endtask

    function automatic exp_t expect_for(input logic g, input logic a, input logic d);
        exp_t e;
        e.g0     = ~g;
        e.g1     = g;
        e.hm     = a;
        e.htrans = a ? bus.HTRANS_M1 : bus.HTRANS_M0;
        e.hwrite = a ? bus.HWRITE_M1 : bus.HWRITE_M0;
        e.hsize  = a ? bus.HSIZE_M1  : bus.HSIZE_M0;
        e.haddr  = a ? bus.HADDR_M1  : bus.HADDR_M0;
        e.hwdata = d ? bus.HWDATA_M1 : bus.HWDATA_M0;
        return e;
    endfunction

    task automatic model_edge();
        logic       ng;
        logic [1:0] tr;
        tr = m_a ? bus.HTRANS_M1 : bus.HTRANS_M0;
        if (!bus.HBUSREQ_M0 && !bus.HBUSREQ_M1)       ng = 1'b0;
        else if (bus.HBUSREQ_M0 != bus.HBUSREQ_M1)    ng = bus.HBUSREQ_M1;
        else if ((m_g != m_a) || (m_b < MAXB))        ng = m_g;
        else                                          ng = ~m_g;
        if (bus.HREADY) begin
            if (m_g != m_a)                 m_b = 0;
            else if (tr[1] && (m_b < MAXB)) m_b = m_b + 1;
            m_d = m_a;
            m_a = m_g;
        end
        m_g = ng;
    endtask

    task automatic model_reset();
        m_g = 1'b0; m_a = 1'b0; m_d = 1'b0; m_b = 0;
    endtask

    task automatic sample_and_edge();
        exp_t e;
        @(negedge HCLK);
        e = sb_q.pop_front();
        chk("grant_m0", 32'(bus.HGRANT_M0), 32'(e.g0));
        chk("grant_m1", 32'(bus.HGRANT_M1), 32'(e.g1));
        chk("hmaster",  32'(bus.HMASTER),   32'(e.hm));
        chk("htrans",   32'(bus.HTRANS),    32'(e.htrans));
        chk("hwrite",   32'(bus.HWRITE),    32'(e.hwrite));
        chk("hsize",    32'(bus.HSIZE),     32'(e.hsize));
        chk("haddr",    bus.HADDR,          e.haddr);
        chk("hwdata",   bus.HWDATA,         e.hwdata);
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic step(input logic r0, input logic r1, input logic [1:0] t0,
                        input logic [1:0] t1, input logic rdy);
        drive(r0, r1, t0, t1, rdy);
        sb_q.push_back(expect_for(m_g, m_a, m_d));
        sample_and_edge();
    endtask

    task automatic step_hand(input vec_t v);
        drive(v.r0, v.r1, v.t0, v.t1, v.rdy);
        sb_q.push_back(expect_for(v.eg, v.ehm, v.edm));
        sample_and_edge();
    endtask

    initial begin
        int n;
        int flips;
        int first_flip;
        int second_flip;
        logic prev_g;

        // {r0, r1, t0, t1, rdy, expected grant, HMASTER, data owner}
        tab[0]  = '{1'b0, 1'b0, IDLE, IDLE,   1'b1, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b1, IDLE, NONSEQ, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 1'b1, IDLE, NONSEQ, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{1'b0, 1'b1, IDLE, NONSEQ, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b1, 1'b1, 1'b1, 1'b1};
        tab[5]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b0, 1'b0, 1'b1, 1'b1};
        tab[6]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b0, 1'b0, 1'b1, 1'b1};
        tab[7]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b0, 1'b0, 1'b1, 1'b1};
        tab[8]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b1, 1'b0, 1'b1, 1'b1};
        tab[9]  = '{1'b1, 1'b0, IDLE, IDLE,   1'b1, 1'b0, 1'b0, 1'b1};
        tab[10] = '{1'b1, 1'b0, IDLE, IDLE,   1'b1, 1'b0, 1'b0, 1'b0};

        HRESET = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, IDLE, IDLE, 1'b1);
        #2;
        chk("reset_grant_m0", 32'(bus.HGRANT_M0), 32'd1);
        chk("reset_grant_m1", 32'(bus.HGRANT_M1), 32'd0);
        chk("reset_hmaster",  32'(bus.HMASTER),   32'd0);
        chk("reset_htrans",   32'(bus.HTRANS),    32'(IDLE));
        chk("reset_haddr",    bus.HADDR,          bus.HADDR_M0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Request latency and stalled handover, hand-derived per cycle
        for (int i = 0; i < 11; i++) begin
            step_hand(tab[i]);
        end

        // M1 request drops in the cycle M0's tenure saturates
        n = 0;
        while (!((m_g == 1'b0) && (m_a == 1'b0) && (m_b == MAXB)) && (n < 60)) begin
            step(1'b1, 1'b1, SEQ, SEQ, 1'b1);
            n++;
        end
        chk("saturation_reached", 32'(n < 60), 32'd1);
        step(1'b1, 1'b0, SEQ, IDLE, 1'b1);
        chk("sat_drop_grant_m0", 32'(bus.HGRANT_M0), 32'd1);
        step(1'b1, 1'b1, SEQ, NONSEQ, 1'b1);
        chk("rerequest_grant_m1", 32'(bus.HGRANT_M1), 32'd1);

        // Reset asserted mid-burst owned by M1, checked before any clock edge
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, IDLE, SEQ, 1'b1);
        end
        chk("pre_reset_hmaster", 32'(bus.HMASTER), 32'd1);
        drive(1'b0, 1'b1, NONSEQ, SEQ, 1'b1);
        HRESET = 1'b1;
        #1;
        chk("async_rst_hmaster",  32'(bus.HMASTER),   32'd0);
        chk("async_rst_grant_m0", 32'(bus.HGRANT_M0), 32'd1);
        chk("async_rst_grant_m1", 32'(bus.HGRANT_M1), 32'd0);
        chk("async_rst_haddr",    bus.HADDR,          bus.HADDR_M0);
        chk("async_rst_htrans",   32'(bus.HTRANS),    32'(bus.HTRANS_M0));
        chk("async_rst_hwdata",   bus.HWDATA,         bus.HWDATA_M0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();

        // Round-robin period under continuous dual requests: 10 edges per tenure
        flips = 0; first_flip = 0; second_flip = 0;
        prev_g = bus.HGRANT_M1;
        for (int i = 0; (i < 60) && (flips < 2); i++) begin
            step(1'b1, 1'b1, SEQ, SEQ, 1'b1);
            if (bus.HGRANT_M1 !== prev_g) begin
                flips++;
                if (flips == 1) first_flip = i;
                else            second_flip = i;
            end
            prev_g = bus.HGRANT_M1;
        end
        chk("rr_two_flips", 32'(flips), 32'd2);
        chk("rr_period",    32'(second_flip - first_flip), 32'd10);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
